// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: holds decode until the source operand is
// hazard-free, resolves BEQZ/BNEZ/BLTZ/BGEZ and issues a one-cycle redirect.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid            decode holds a valid instruction
//   id_branchCtl[3:0]   bit2 = conditional branch, bits[1:0] = condition
//   id_rsData           forwarded source operand
//   id_rsReady          id_rsData is hazard-free
//   id_pcPlus2, id_imm  branch PC+2 and sign-extended offset
//   ex_flush            external squash
//   stall_id            hold IF/ID this cycle
//   flush_if            squash the instruction in IF
//   redirect_valid/pc   PC redirect request and target
//   branch_done         a branch resolved this cycle
//   cond_taken          resolution result, qualified by branch_done
//   taken_cnt           saturating taken-branch count
//   nottaken_cnt        saturating not-taken-branch count
module branch_sequencer #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_branchCtl,
    input  logic [PC_W-1:0]  id_rsData,
    input  logic             id_rsReady,
    input  logic [PC_W-1:0]  id_pcPlus2,
    input  logic [PC_W-1:0]  id_imm,
    input  logic             ex_flush,
    output logic             stall_id,
    output logic             flush_if,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             branch_done,
    output logic             cond_taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cond_q, cond_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [PC_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

    logic new_br;
    logic taken;
    logic resolve_ok;

    // bit3 of the branch control carries no meaning here
    logic unused_ctl;
    assign unused_ctl = id_branchCtl[3];

    assign new_br = id_valid & id_branchCtl[2];

    // Condition is evaluated on captured state only, so no id_* input
    // reaches the redirect outputs combinationally.
    always_comb begin
        taken = 1'b0;
        unique case (cond_q)
            2'b00: taken = (data_q == '0);
            2'b01: taken = (data_q != '0);
            2'b10: taken = data_q[PC_W-1];
            2'b11: taken = ~data_q[PC_W-1];
            default: taken = 1'b0;
        endcase
    end

    assign resolve_ok = (state_q == RESOLVE) & ~ex_flush;

    always_comb begin
        state_d        = state_q;
        cond_d         = cond_q;
        target_d       = target_q;
        data_d         = data_q;
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (ex_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (new_br) begin
                        cond_d   = id_branchCtl[1:0];
                        target_d = id_pcPlus2 + id_imm;
                        if (id_rsReady) begin
                            data_d  = id_rsData;
                            state_d = RESOLVE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (id_rsReady) begin
                        data_d  = id_rsData;
                        state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    state_d = IDLE;
                    if (taken) begin
                        if (taken_cnt_q != '1)
                            taken_cnt_d = taken_cnt_q + CNT_W'(1);
                    end else begin
                        if (nottaken_cnt_q != '1)
                            nottaken_cnt_d = nottaken_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cond_q         <= '0;
            target_q       <= '0;
            data_q         <= '0;
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cond_q         <= cond_d;
            target_q       <= target_d;
            data_q         <= data_d;
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    // The only id_*-dependent output is the accept stall in IDLE.
    assign stall_id = ~ex_flush &
                      (((state_q == IDLE) & new_br) | (state_q == WAIT));

    assign branch_done    = resolve_ok;
    assign cond_taken     = resolve_ok & taken;
    assign redirect_valid = resolve_ok & taken;
    assign flush_if       = resolve_ok & taken;
    assign redirect_pc    = target_q;
    assign taken_cnt      = taken_cnt_q;
    assign nottaken_cnt   = nottaken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a resolution scoreboard.
// Runs with CNT_W=2 so counter saturation is reachable quickly.
module tb_branch_sequencer;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_branchCtl;
    logic [15:0] id_rsData;
    logic        id_rsReady;
    logic [15:0] id_pcPlus2;
    logic [15:0] id_imm;
    logic        ex_flush;
    logic        stall_id;
    logic        flush_if;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        branch_done;
    logic        cond_taken;
    logic [1:0]  taken_cnt;
    logic [1:0]  nottaken_cnt;

    typedef struct packed {
        logic        t;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_sequencer #(.CNT_W(2), .PC_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_branchCtl  (id_branchCtl),
        .id_rsData     (id_rsData),
        .id_rsReady    (id_rsReady),
        .id_pcPlus2    (id_pcPlus2),
        .id_imm        (id_imm),
        .ex_flush      (ex_flush),
        .stall_id      (stall_id),
        .flush_if      (flush_if),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .branch_done   (branch_done),
        .cond_taken    (cond_taken),
        .taken_cnt     (taken_cnt),
        .nottaken_cnt  (nottaken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every branch_done pops one expected resolution.
    always @(negedge clk) begin
        if (!rst) begin
            if (branch_done) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_cond_taken", 32'(cond_taken), 32'(e.t));
                    chk("sb_redir_valid", 32'(redirect_valid), 32'(e.t));
                    chk("sb_flush_if", 32'(flush_if), 32'(e.t));
                    chk("sb_redir_pc", 32'(redirect_pc), 32'(e.pc));
                end
            end else begin
                chk("quiet_redirect",
                    32'({redirect_valid, flush_if, cond_taken}), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch with operand ready at accept: one stall, then resolve.
    task automatic br_fast(input logic [3:0] ctl, input logic [15:0] d,
                           input logic [15:0] pc, input logic [15:0] imm,
                           input logic t);
        logic [15:0] tgt;
        tgt          = pc + imm;
        id_valid     = 1'b1;
        id_branchCtl = ctl;
        id_rsData    = d;
        id_rsReady   = 1'b1;
        id_pcPlus2   = pc;
        id_imm       = imm;
        exp_q.push_back('{t: t, pc: tgt});
        @(negedge clk);
        chk("stall_accept", 32'(stall_id), 1);
        tick();
        id_valid   = 1'b0;
        id_rsReady = 1'b0;
        @(negedge clk);
        chk("stall_resolve", 32'(stall_id), 0);
        chk("done_resolve", 32'(branch_done), 1);
        tick();
    endtask

    logic [3:0]  sat_ctl [5];
    logic [15:0] sat_dat [5];

    initial begin
        sat_ctl = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0100};
        sat_dat = '{16'h0000, 16'h0005, 16'h8001, 16'h0000, 16'h0000};
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_branchCtl = 4'h0;
        id_rsData    = 16'h0;
        id_rsReady   = 1'b0;
        id_pcPlus2   = 16'h0;
        id_imm       = 16'h0;
        ex_flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_stall", 32'(stall_id), 0);
        chk("rst_flush_if", 32'(flush_if), 0);
        chk("rst_redir_valid", 32'(redirect_valid), 0);
        chk("rst_redir_pc", 32'(redirect_pc), 0);
        chk("rst_done", 32'(branch_done), 0);
        chk("rst_cond", 32'(cond_taken), 0);
        chk("rst_taken_cnt", 32'(taken_cnt), 0);
        chk("rst_nt_cnt", 32'(nottaken_cnt), 0);
        tick();

        // non-branch passes through
        id_valid     = 1'b1;
        id_branchCtl = 4'b0000;
        id_rsReady   = 1'b1;
        @(negedge clk);
        chk("nobr_stall", 32'(stall_id), 0);
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("nobr_stall2", 32'(stall_id), 0);
        chk("nobr_done", 32'(branch_done), 0);
        tick();

        // BEQZ taken
        br_fast(4'b0100, 16'h0000, 16'h0102, 16'h0010, 1'b1);
        chk("beqz_taken_cnt", 32'(taken_cnt), 1);
        chk("beqz_nt_cnt", 32'(nottaken_cnt), 0);

        // BLTZ waits 3 cycles for its operand, not taken
        id_valid     = 1'b1;
        id_branchCtl = 4'b0110;
        id_rsData    = 16'h7FFF;
        id_rsReady   = 1'b0;
        id_pcPlus2   = 16'h0200;
        id_imm       = 16'h0020;
        exp_q.push_back('{t: 1'b0, pc: 16'h0220});
        for (int i = 0; i < 4; i++) begin
            if (i == 3) id_rsReady = 1'b1;
            @(negedge clk);
            chk("bltz_wait_stall", 32'(stall_id), 1);
            chk("bltz_wait_done", 32'(branch_done), 0);
            tick();
        end
        id_valid   = 1'b0;
        id_rsReady = 1'b0;
        @(negedge clk);
        chk("bltz_res_stall", 32'(stall_id), 0);
        chk("bltz_res_done", 32'(branch_done), 1);
        tick();
        chk("bltz_nt_cnt", 32'(nottaken_cnt), 1);
        chk("bltz_taken_cnt", 32'(taken_cnt), 1);

        // BGEZ with target wrap; BNEZ on negative with bit3 set
        br_fast(4'b0111, 16'h0001, 16'hFFFE, 16'h0004, 1'b1);
        br_fast(4'b1101, 16'h8000, 16'h1000, 16'hFFF0, 1'b1);
        // not-taken BEQZ and BGEZ
        br_fast(4'b0100, 16'h0001, 16'h0300, 16'h0002, 1'b0);
        br_fast(4'b0111, 16'h8000, 16'h0310, 16'h0040, 1'b0);
        chk("mix_taken_cnt", 32'(taken_cnt), 3);
        chk("mix_nt_cnt", 32'(nottaken_cnt), 3);

        // ex_flush while in WAIT
        id_valid     = 1'b1;
        id_branchCtl = 4'b0100;
        id_rsData    = 16'h0000;
        id_rsReady   = 1'b0;
        id_pcPlus2   = 16'h0400;
        id_imm       = 16'h0010;
        @(negedge clk);
        chk("fw_accept_stall", 32'(stall_id), 1);
        tick();
        ex_flush = 1'b1;
        @(negedge clk);
        chk("fw_stall", 32'(stall_id), 0);
        chk("fw_done", 32'(branch_done), 0);
        tick();
        ex_flush = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("fw_idle_stall", 32'(stall_id), 0);
        chk("fw_idle_done", 32'(branch_done), 0);
        chk("fw_taken_cnt", 32'(taken_cnt), 3);
        tick();

        // ex_flush while in RESOLVE of a taken branch
        id_valid   = 1'b1;
        id_rsReady = 1'b1;
        @(negedge clk);
        chk("fr_accept_stall", 32'(stall_id), 1);
        tick();
        id_valid   = 1'b0;
        id_rsReady = 1'b0;
        ex_flush   = 1'b1;
        @(negedge clk);
        chk("fr_done", 32'(branch_done), 0);
        chk("fr_redir", 32'(redirect_valid), 0);
        chk("fr_flush_if", 32'(flush_if), 0);
        chk("fr_stall", 32'(stall_id), 0);
        tick();
        ex_flush = 1'b0;
        @(negedge clk);
        chk("fr_idle_done", 32'(branch_done), 0);
        chk("fr_taken_cnt", 32'(taken_cnt), 3);
        chk("fr_nt_cnt", 32'(nottaken_cnt), 3);
        tick();

        // branch arriving with ex_flush in IDLE is dropped
        id_valid   = 1'b1;
        id_rsReady = 1'b1;
        ex_flush   = 1'b1;
        @(negedge clk);
        chk("fi_stall", 32'(stall_id), 0);
        tick();
        id_valid = 1'b0;
        ex_flush = 1'b0;
        @(negedge clk);
        chk("fi_done", 32'(branch_done), 0);
        chk("fi_stall2", 32'(stall_id), 0);
        tick();

        // rst while in WAIT
        id_valid   = 1'b1;
        id_rsReady = 1'b0;
        @(negedge clk);
        chk("rw_accept_stall", 32'(stall_id), 1);
        tick();
        @(negedge clk);
        chk("rw_wait_stall", 32'(stall_id), 1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("rw_stall", 32'(stall_id), 0);
        chk("rw_done", 32'(branch_done), 0);
        chk("rw_taken_cnt", 32'(taken_cnt), 0);
        chk("rw_nt_cnt", 32'(nottaken_cnt), 0);
        chk("rw_redir_pc", 32'(redirect_pc), 0);
        tick();

        // five taken branches saturate the 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            br_fast(sat_ctl[i], sat_dat[i], 16'(16'h0100 + i * 4),
                    16'h0008, 1'b1);
            chk("sat_taken_cnt", 32'(taken_cnt), (i < 2) ? i + 1 : 3);
            chk("sat_nt_cnt", 32'(nottaken_cnt), 0);
        end

        repeat (2) tick();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
